// File: rtl/conv_feeder.sv
// Front-end sequencer for the ternary 3x3 convolution: serial weight load,
// raster pixel stream to packed 3x3 windows, and a latency-matched result strobe.
module conv_feeder #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int CONV_LAT = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_start,
    input  logic [17:0] i_wgt,
    input  logic        i_pix_valid,
    input  logic [1:0]  i_pix,
    output logic        o_pix_ready,
    output logic        o_w_req,
    output logic [1:0]  o_w_data,
    output logic [17:0] o_win,
    output logic        o_win_valid,
    output logic        o_res_valid,
    output logic        o_busy,
    output logic        o_done
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DEPTH = 1 << CW;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, FLUSH} state_t;

    state_t              state;
    logic [17:0]         wgt;
    logic [3:0]          k;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [1:0]          lb1 [DEPTH];
    logic [1:0]          lb2 [DEPTH];
    logic [CONV_LAT-1:0] vld_p;
    logic                accept;

    assign accept      = i_pix_valid && o_pix_ready;
    assign o_res_valid = vld_p[CONV_LAT-1];

    // Line buffers hold rows r-1 / r-2; their contents never need clearing.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= i_pix;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            wgt         <= '0;
            k           <= '0;
            col         <= '0;
            row         <= '0;
            vld_p       <= '0;
            o_pix_ready <= 1'b0;
            o_w_req     <= 1'b0;
            o_w_data    <= '0;
            o_win       <= '0;
            o_win_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_win_valid <= 1'b0;
            o_done      <= 1'b0;
            vld_p       <= CONV_LAT'({vld_p, o_win_valid});
            case (state)
                IDLE: begin
                    if (i_start) begin
                        wgt      <= {2'b00, i_wgt[17:2]};
                        o_w_data <= i_wgt[1:0];
                        o_w_req  <= 1'b1;
                        k        <= 4'd1;
                        col      <= '0;
                        row      <= '0;
                        o_busy   <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // Exactly nine request cycles; the conv weight index saturates at 9.
                    if (k == 4'd9) begin
                        o_w_req     <= 1'b0;
                        o_w_data    <= '0;
                        o_pix_ready <= 1'b1;
                        state       <= STREAM;
                    end else begin
                        o_w_data <= wgt[1:0];
                        wgt      <= {2'b00, wgt[17:2]};
                        k        <= k + 4'd1;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        // Column-major packing: new right column is {i_pix, r-1, r-2} bottom to top.
                        o_win       <= {i_pix, lb1[col], lb2[col], o_win[17:6]};
                        o_win_valid <= (row >= RW'(2)) && (col >= CW'(2));
                        if (col == CW'(IMG_W - 1)) begin
                            col <= '0;
                            if (row == RW'(IMG_H - 1)) begin
                                row         <= '0;
                                o_pix_ready <= 1'b0;
                                state       <= FLUSH;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (!o_win_valid && (vld_p == '0)) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder: a 4x4 instance for hand-computed windows and
// a 28x28 instance for full frames, resets mid-frame and start-while-busy.
module tb_conv_feeder;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_start;
    logic [17:0] i_wgt;
    logic        i_pix_valid;
    logic [1:0]  i_pix;
    bit          sel;

    logic        s_pix_ready, s_w_req, s_win_valid, s_res_valid, s_busy, s_done;
    logic [1:0]  s_w_data;
    logic [17:0] s_win;
    logic        l_pix_ready, l_w_req, l_win_valid, l_res_valid, l_busy, l_done;
    logic [1:0]  l_w_data;
    logic [17:0] l_win;

    conv_feeder #(.IMG_W(4), .IMG_H(4), .CONV_LAT(LAT)) dut_s (
        .clk(clk), .resetn(resetn), .i_start(i_start), .i_wgt(i_wgt),
        .i_pix_valid(i_pix_valid), .i_pix(i_pix), .o_pix_ready(s_pix_ready),
        .o_w_req(s_w_req), .o_w_data(s_w_data), .o_win(s_win),
        .o_win_valid(s_win_valid), .o_res_valid(s_res_valid),
        .o_busy(s_busy), .o_done(s_done));

    conv_feeder #(.IMG_W(28), .IMG_H(28), .CONV_LAT(LAT)) dut_l (
        .clk(clk), .resetn(resetn), .i_start(i_start), .i_wgt(i_wgt),
        .i_pix_valid(i_pix_valid), .i_pix(i_pix), .o_pix_ready(l_pix_ready),
        .o_w_req(l_w_req), .o_w_data(l_w_data), .o_win(l_win),
        .o_win_valid(l_win_valid), .o_res_valid(l_res_valid),
        .o_busy(l_busy), .o_done(l_done));

    wire        pix_ready = sel ? l_pix_ready : s_pix_ready;
    wire        w_req     = sel ? l_w_req     : s_w_req;
    wire [1:0]  w_data    = sel ? l_w_data    : s_w_data;
    wire [17:0] win       = sel ? l_win       : s_win;
    wire        win_valid = sel ? l_win_valid : s_win_valid;
    wire        res_valid = sel ? l_res_valid : s_res_valid;
    wire        busy      = sel ? l_busy      : s_busy;
    wire        done      = sel ? l_done      : s_done;
    wire [25:0] outs      = {pix_ready, w_req, w_data, win, win_valid, res_valid, busy, done};

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          w, h;
    logic [1:0]  pix [784];
    logic [17:0] win_q [$];
    int          wv_q [$];
    int          rv_q [$];
    int          n_done;
    int          done_cyc;
    logic [17:0] wgt_a, wgt_b;
    logic [17:0] exp_s [4] = '{18'h11111, 18'h04444, 18'h04444, 18'h11111};
    int          exp_c [4] = '{5, 4, 4, 5};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (win_valid) begin
            win_q.push_back(win);
            wv_q.push_back(cyc);
        end
        if (res_valid) rv_q.push_back(cyc);
        if (done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int tern(input logic [1:0] v);
        return (v == 2'b01) ? 1 : (v == 2'b11) ? -1 : 0;
    endfunction

    function automatic int dot(input logic [17:0] wn, input logic [17:0] wg);
        int s = 0;
        for (int i = 0; i < 9; i++) s += tern(wn[2*i +: 2]) * tern(wg[2*i +: 2]);
        return s;
    endfunction

    // Window whose bottom-right pixel is (r, c), packed column-major.
    function automatic logic [17:0] exp_win(input int r, input int c);
        logic [17:0] e = '0;
        for (int wc = 0; wc < 3; wc++)
            for (int wr = 0; wr < 3; wr++)
                e[2*(3*wc+wr) +: 2] = pix[(r-2+wr)*w + (c-2+wc)];
        return e;
    endfunction

    task automatic clear_mon();
        win_q.delete();
        wv_q.delete();
        rv_q.delete();
        n_done   = 0;
        done_cyc = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        i_start     = 1'b0;
        i_pix_valid = 1'b0;
        resetn      = 1'b0;
        #1;
        chk(tag, int'(outs), 0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Start a frame and check the nine-cycle weight handshake.
    task automatic chk_load(input logic [17:0] wg, input bit now, input bit busy_pulse);
        if (!now) @(negedge clk);
        i_start = 1'b1;
        i_wgt   = wg;
        @(negedge clk);
        i_start = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            if (j == 1) chk("busy_load", busy, 1);
            if (j <= 9) begin
                chk("w_req", w_req, 1);
                chk("w_data", w_data, wg[2*(j-1) +: 2]);
                chk("ready_load", pix_ready, 0);
            end else begin
                chk("w_req_end", w_req, 0);
                chk("w_data_end", w_data, 0);
                chk("ready_stream", pix_ready, 1);
            end
            if (busy_pulse && j == 3) begin
                i_start = 1'b1;
                i_wgt   = ~wg;
            end else begin
                i_start = 1'b0;
            end
            if (j < 10) @(negedge clk);
        end
    endtask

    task automatic feed(input int n, input bit gaps, input int start_at);
        int t = 0;
        while (!pix_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", int'(t < 50), 1);
        for (int i = 0; i < n; i++) begin
            i_pix_valid = 1'b1;
            i_pix       = pix[i];
            i_start     = (i == start_at);
            if (i == start_at) i_wgt = ~i_wgt;
            @(negedge clk);
            i_start = 1'b0;
            if (gaps) begin
                i_pix_valid = 1'b0;
                @(negedge clk);
            end
        end
        i_pix_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait", int'(t < 100), 1);
        #1;
        chk("busy_at_done", busy, 0);
    endtask

    task automatic check_frame(input string tag);
        int nw = (w - 2) * (h - 2);
        chk({tag, "_nwin"}, win_q.size(), nw);
        chk({tag, "_nres"}, rv_q.size(), nw);
        chk({tag, "_ndone"}, n_done, 1);
        for (int i = 0; i < win_q.size() && i < nw; i++)
            chk({tag, "_win"}, int'(win_q[i]), int'(exp_win(2 + i / (w - 2), 2 + i % (w - 2))));
        for (int i = 0; i < rv_q.size() && i < wv_q.size(); i++)
            chk({tag, "_lat"}, rv_q[i] - wv_q[i], LAT);
        if (rv_q.size() > 0) chk({tag, "_done_lat"}, done_cyc - rv_q[rv_q.size()-1], 2);
    endtask

    task automatic rand_image();
        for (int i = 0; i < 784; i++)
            case ($urandom_range(2))
                0:       pix[i] = 2'b00;
                1:       pix[i] = 2'b01;
                default: pix[i] = 2'b11;
            endcase
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; i_start = 1'b0; i_wgt = '0; i_pix_valid = 1'b0; i_pix = '0;
        sel = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_s", int'(outs), 0);
        sel = 1'b1;
        #1;
        chk("rst_l", int'(outs), 0);
        sel = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Small 4x4 checkerboard
        w = 4; h = 4;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pix[r*4+c] = ((r + c) % 2 == 0) ? 2'b01 : 2'b00;

        clear_mon();
        chk_load(18'h3FFC0, 1'b0, 1'b0);
        feed(16, 1'b0, -1);
        wait_done();
        check_frame("t1");

        clear_mon();
        chk_load(18'h15555, 1'b0, 1'b0);
        feed(16, 1'b0, -1);
        wait_done();
        check_frame("t2");
        for (int i = 0; i < 4 && i < win_q.size(); i++) begin
            chk("t2_hand_win", int'(win_q[i]), int'(exp_s[i]));
            chk("t2_conv", dot(win_q[i], 18'h15555), exp_c[i]);
        end

        clear_mon();
        chk_load(18'h15555, 1'b0, 1'b0);
        feed(16, 1'b1, -1);
        wait_done();
        check_frame("t3");
        for (int i = 0; i < 4 && i < win_q.size(); i++)
            chk("t3_hand_win", int'(win_q[i]), int'(exp_s[i]));
        for (int i = 1; i < rv_q.size() && i < wv_q.size(); i++)
            chk("t3_spacing", rv_q[i] - rv_q[i-1], wv_q[i] - wv_q[i-1]);

        // Default 28x28 frames
        sel = 1'b1;
        do_reset("t4_rst");
        w = 28; h = 28;
        rand_image();
        wgt_a = 18'($urandom);
        clear_mon();
        chk_load(wgt_a, 1'b0, 1'b0);
        feed(784, 1'b0, -1);
        wait_done();
        check_frame("t4");

        // Reset during LOAD, then during STREAM at row 10
        @(negedge clk);
        i_start = 1'b1; i_wgt = wgt_a;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_in_load", w_req, 1);
        do_reset("t5_rst_load");
        clear_mon();
        chk_load(wgt_a, 1'b0, 1'b0);
        feed(10 * 28 + 5, 1'b0, -1);
        chk("t5_in_stream", pix_ready, 1);
        do_reset("t5_rst_stream");
        rand_image();
        wgt_b = 18'($urandom);
        clear_mon();
        chk_load(wgt_b, 1'b0, 1'b0);
        feed(784, 1'b0, -1);
        wait_done();
        check_frame("t5");

        // Start pulses while busy are ignored; start right after done is taken
        rand_image();
        clear_mon();
        chk_load(wgt_a, 1'b0, 1'b1);
        feed(784, 1'b0, 300);
        wait_done();
        check_frame("t6a");
        clear_mon();
        chk_load(wgt_b, 1'b1, 1'b0);
        feed(784, 1'b0, -1);
        wait_done();
        check_frame("t6b");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
